// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order writeback FIFO owning the regfile write port (R0 never written).
// Define REGFILE_WB_BYPASS_EN to build the combinational operand-bypass lookups.
module regfile_wb_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_W-1:0]  in_dest,
  input  logic [DATA_W-1:0] in_data,
  input  logic              stall,
  output logic [REG_W-1:0]  regDestination,
  output logic [DATA_W-1:0] writeData,
  output logic              writeEnable,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  input  logic [REG_W-1:0]  lookupReg1,
  input  logic [REG_W-1:0]  lookupReg2,
  output logic              lookupHit1,
  output logic              lookupHit2,
  output logic [DATA_W-1:0] lookupData1,
  output logic [DATA_W-1:0] lookupData2
);
  localparam int ENT_W = REG_W + DATA_W;
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              we_q, we_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              push, pop;
  assign empty          = count_q == '0;
  assign full           = count_q == (PTR_W+1)'(DEPTH);
  assign in_ready       = !full;
  assign count          = count_q;
  assign writeEnable    = we_q;
  assign regDestination = rd_q;
  assign writeData      = wd_q;
  // R0 results complete the handshake but are dropped here
  assign push = in_valid && !full && in_dest != '0;
  assign pop  = !empty && !stall;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[tail_q] = {in_dest, in_data};
    tail_d       = push ? tail_q + PTR_W'(1) : tail_q;
    head_d       = pop ? head_q + PTR_W'(1) : head_q;
    count_d      = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    we_d         = pop;
    {rd_d, wd_d} = pop ? mem_q[head_q] : {rd_q, wd_q};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      rd_q    <= '0;
      wd_q    <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      wd_q    <= wd_d;
    end
  end
`ifdef REGFILE_WB_BYPASS_EN
  // Scan oldest to youngest so the youngest match overwrites earlier ones
  function automatic logic [DATA_W:0] lookup(input logic [REG_W-1:0] r);
    logic [DATA_W:0]  res;
    logic [PTR_W-1:0] idx;
    res = '0;
    if (r != '0) begin
      if (we_q && rd_q == r) res = {1'b1, wd_q};
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if ((PTR_W+1)'(i) < count_q && mem_q[idx][ENT_W-1 -: REG_W] == r)
          res = {1'b1, mem_q[idx][DATA_W-1:0]};
      end
    end
    return res;
  endfunction
  assign {lookupHit1, lookupData1} = lookup(lookupReg1);
  assign {lookupHit2, lookupData2} = lookup(lookupReg2);
`else
  logic unused_lookup;
  assign unused_lookup = ^{lookupReg1, lookupReg2};
  assign {lookupHit1, lookupData1} = '0;
  assign {lookupHit2, lookupData2} = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed stimulus with a scoreboard model of the writeback queue.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, stall;
  logic [2:0]  in_dest, regDestination, lookupReg1, lookupReg2;
  logic [15:0] in_data, writeData, lookupData1, lookupData2;
  logic        writeEnable, empty, full, lookupHit1, lookupHit2;
  logic [2:0]  count;
  int          checks = 0;
  int          errors = 0;
  int          mcount = 0;
  logic [18:0] sb[$];
  regfile_wb_queue dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .stall(stall),
    .regDestination(regDestination), .writeData(writeData), .writeEnable(writeEnable),
    .count(count), .empty(empty), .full(full),
    .lookupReg1(lookupReg1), .lookupReg2(lookupReg2),
    .lookupHit1(lookupHit1), .lookupHit2(lookupHit2),
    .lookupData1(lookupData1), .lookupData2(lookupData2)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // One clock: predict push/pop from the model, then compare after the edge
  task automatic step();
    logic        st, pp;
    logic [18:0] e;
    e  = '0;
    st = in_valid && mcount < DEPTH && in_dest != 3'd0;
    pp = mcount > 0 && !stall;
    if (st) sb.push_back({in_dest, in_data});
    if (pp) e = sb.pop_front();
    mcount = mcount + int'(st) - int'(pp);
    @(posedge clock);
    #1;
    chk("writeEnable", 32'(writeEnable), 32'(pp));
    if (pp) chk("write", 32'({regDestination, writeData}), 32'(e));
    chk("count", 32'(count), 32'(mcount));
    chk("in_ready", 32'(in_ready), 32'(mcount < DEPTH));
    chk("full", 32'(full), 32'(mcount == DEPTH));
    chk("empty", 32'(empty), 32'(mcount == 0));
  endtask
  task automatic push(input logic [2:0] d, input logic [15:0] v);
    in_valid = 1'b1;
    in_dest  = d;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'(writeEnable), 0);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_wr"}, 32'({regDestination, writeData}), 0);
    chk({tag, "_flags"}, 32'({empty, full, in_ready}), 32'b101);
    chk({tag, "_lookup"}, 32'({lookupHit1, lookupHit2, lookupData1, lookupData2}), 0);
  endtask
  initial begin
    reset = 1'b1;
    {in_valid, stall, in_dest, in_data, lookupReg1, lookupReg2} = '0;
    lookupReg1 = 3'd2;
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    lookupReg1 = 3'd0;
    push(3'd2, 16'h23FE);
    repeat (2) step();
    push(3'd0, 16'hFFFF);
    repeat (3) step();
    stall = 1'b1;
    push(3'd1, 16'h1111);
    push(3'd2, 16'h2222);
    push(3'd3, 16'h3333);
    push(3'd4, 16'h4444);
    in_valid = 1'b1;
    in_dest  = 3'd5;
    in_data  = 16'h5555;
    repeat (2) step();
    stall = 1'b0;
    repeat (2) step();
    in_valid = 1'b0;
    repeat (6) step();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_dest  = 3'(i % 7 + 1);
      in_data  = 16'($urandom);
      step();
      chk("stream_count_le1", 32'(count <= 3'd1), 1);
    end
    in_valid = 1'b0;
    repeat (3) step();
    stall = 1'b1;
    push(3'd6, 16'hA0A0);
    push(3'd7, 16'hB1B1);
    push(3'd3, 16'hC2C2);
    push(3'd5, 16'hD3D3);
    stall = 1'b0;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    sb.delete();
    mcount = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (4) step();
    stall = 1'b1;
    push(3'd4, 16'h6781);
    push(3'd4, 16'h1234);
    lookupReg1 = 3'd4;
    lookupReg2 = 3'd0;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    chk("bypass1", 32'({lookupHit1, lookupData1}), 32'h11234);
`else
    chk("bypass1", 32'({lookupHit1, lookupData1}), 0);
`endif
    chk("bypass2_r0", 32'({lookupHit2, lookupData2}), 0);
    lookupReg2 = 3'd1;
    #1;
    chk("bypass2_miss", 32'({lookupHit2, lookupData2}), 0);
    stall = 1'b0;
    lookupReg1 = 3'd0;
    repeat (4) step();
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Writeback queue that owns the write port of the 8x16 register file (R0 hardwired to zero).
- Execute and memory-load stages push (destination, data) results through a valid/ready handshake.
- Results are buffered in a small FIFO and drained in order, one register write per cycle, onto the regfile's regDestination / writeData / writeEnable inputs.
- An optional read-bypass lets operand fetch see results still in flight.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, minimum 2.
- PTR_W, 2, log2(DEPTH).
- DATA_W, 16, data width; matches the regfile word.
- REG_W, 3, register index width (8 registers).

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- in_valid  input  1  producer has a result.
- in_ready  output  1  queue can accept; equals !full.
- in_dest  input  REG_W  destination register of the result.
- in_data  input  DATA_W  result value.
- stall  input  1  regfile write port unavailable this cycle; suppresses the pop.
- regDestination  output  REG_W  to regfile write address.
- writeData  output  DATA_W  to regfile write data.
- writeEnable  output  1  to regfile write enable.
- count  output  PTR_W+1  number of FIFO entries held (0..DEPTH).
- empty  output  1  count==0.
- full  output  1  count==DEPTH.
- lookupReg1  input  REG_W  bypass query 1.
- lookupReg2  input  REG_W  bypass query 2.
- lookupHit1  output  1  bypass query 1 hit.
- lookupHit2  output  1  bypass query 2 hit.
- lookupData1  output  DATA_W  bypass query 1 data.
- lookupData2  output  DATA_W  bypass query 2 data.

Behaviour:
- Reset (async, any time, including mid-drain):
  - head and tail pointers and count = 0.
  - writeEnable = 0, regDestination = 0, writeData = 0.
  - Queued entries are discarded.
  - empty = 1, full = 0, in_ready = 1; all lookup outputs = 0.
- Push: handshake completes on a posedge with in_valid && in_ready.
  - in_dest == 0: handshake completes but nothing is stored. R0 is never written; count is unchanged.
  - Otherwise {in_dest, in_data} is written at tail, tail increments mod DEPTH.
- Pop (output register stage):
  - On every posedge, if !empty && !stall: the head entry is loaded into regDestination/writeData, writeEnable = 1, head increments mod DEPTH.
  - Otherwise writeEnable = 0; regDestination and writeData hold their previous values.
  - writeEnable is high for exactly one cycle per popped entry.
- Latency:
  - A result pushed at edge N into an empty queue drives writeEnable=1 during cycle N+1..N+2.
  - The regfile captures it at edge N+2.
  - In-order drain; no reordering and no coalescing of same-destination writes.
- Simultaneous push and pop in the same edge: both happen, count unchanged. Allowed at any non-full count.
- Full:
  - in_ready = 0 even if a pop occurs this edge (no combinational ready path from stall).
  - A push attempted while full is ignored; the producer must hold in_valid.
- Empty: no pop, writeEnable = 0, stall has no effect.
- Pointer wrap: natural mod-DEPTH wrap; count distinguishes full from empty.
- count, empty and full are registered and reflect state after the edge.
- stall held indefinitely: the queue fills to DEPTH and holds all entries intact.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined: lookupHit1/lookupData1 and lookupHit2/lookupData2 are combinational.
  - Candidate entries are all valid FIFO entries plus the output stage while writeEnable=1.
  - A hit occurs when the register index of a candidate matches lookupRegN.
  - Youngest matching entry wins; the tail side is youngest and the output stage is oldest.
  - lookupRegN == 0 never hits.
  - No hit: lookupHitN = 0 and lookupDataN = 0.
- Not defined: lookup ports are present, lookupHit1/2 and lookupData1/2 are tied to 0, and no comparator logic is built.

Test Plan:
- Reset, then push {R2, 0x23FE} with stall=0 -> writeEnable=1, regDestination=2, writeData=0x23FE exactly one cycle later; regfile reads R2=0x23FE after the following edge; count returns to 0.
- Push {R0, 0xFFFF} -> handshake completes, count stays 0, writeEnable never asserts, R0 still reads 0x0000.
- Hold stall=1 and push R1..R4 with 0x1111..0x4444 -> full=1, in_ready=0 after the 4th push, a 5th push of {R5, 0x5555} is held off. Release stall -> four consecutive writeEnable pulses in order R1..R4, then the 5th entry drains.
- Push every cycle while draining every cycle (stall=0) with 8 results -> count never exceeds 1, pointers wrap twice, all 8 writes appear in order.
- Assert reset with 3 entries queued and writeEnable=1 -> writeEnable, count and all outputs go to 0 immediately (asynchronously); no further writes after reset releases.
- With REGFILE_WB_BYPASS_EN and stall=1, push {R4, 0x6781} then {R4, 0x1234}, set lookupReg1=4 and lookupReg2=0 -> lookupHit1=1, lookupData1=0x1234, lookupHit2=0. Without the macro -> both hits 0.
